wb_dcache_mem_bridge: RTL

Memory-side bridge directly downstream of the write-back data-cache datapath. It takes one cache-line request (line fill or dirty-line write-back, 128 bits) and serialises it into a burst of 32-bit single-beat bus transactions toward data memory. It reassembles read beats into a full line, then returns it to the cache with a one-cycle acknowledge. Bus errors abort the burst and are reported back to the cache.

---
 rtl/wb_dcache_mem_bridge_if.sv | 25 ++
 rtl/wb_dcache_mem_bridge.sv | 138 +++++++++++++
 2 files changed

// File: rtl/wb_dcache_mem_bridge_if.sv
// Single-beat memory bus between the dcache bridge and data memory.
// The bridge is the master; the memory (or its model) is the slave.
interface wb_dcache_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
) ();
    logic                   stb;
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [BUS_WIDTH-1:0]   wdata;
    logic [BUS_WIDTH/8-1:0] sel;
    logic [BUS_WIDTH-1:0]   rdata;
    logic                   ack;
    logic                   err;

    modport master (
        output stb, we, addr, wdata, sel,
        input  rdata, ack, err
    );

    modport slave (
        input  stb, we, addr, wdata, sel,
        output rdata, ack, err
    );
endinterface

// File: rtl/wb_dcache_mem_bridge.sv
// Serialises one cache-line fill or write-back into single-beat bus
// transfers and returns the assembled line with a one-cycle ack.
module wb_dcache_mem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_we_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
    output logic                  mem2dcache_ack_o,
    output logic                  mem2dcache_err_o,
    output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
    wb_dcache_mem_bridge_if.master mem
);
    localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BOFF  = $clog2(BUS_WIDTH / 8);
    localparam logic [BCW-1:0] LAST = BCW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [BCW-1:0]          beat_q, beat_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    stb_q, stb_d;
    logic                    mwe_q, mwe_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BUS_WIDTH-1:0]    wdata_q, wdata_d;
    logic [BUS_WIDTH/8-1:0]  sel_q, sel_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [BCW-1:0]          beat_nxt;

    assign acc_addr = dcache2mem_addr_i & ~OFF_MASK;
    assign beat_nxt = beat_q + BCW'(1);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        base_d  = base_q;
        beat_d  = beat_q;
        line_d  = line_q;
        stb_d   = stb_q;
        mwe_d   = mwe_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dcache2mem_req_i) begin
                    state_d = BURST;
                    we_d    = dcache2mem_we_i;
                    base_d  = acc_addr;
                    beat_d  = '0;
                    // Fill lines start cleared so aborted words read as zero
                    line_d  = dcache2mem_we_i ? dcache2mem_data_i : '0;
                    stb_d   = 1'b1;
                    mwe_d   = dcache2mem_we_i;
                    addr_d  = acc_addr;
                    wdata_d = dcache2mem_data_i[BUS_WIDTH-1:0];
                    sel_d   = '1;
                end
            end
            BURST: begin
                if (mem.err || (mem.ack && beat_q == LAST)) begin
                    if (!mem.err && !we_q)
                        line_d[BUS_WIDTH*beat_q +: BUS_WIDTH] = mem.rdata;
                    state_d = DONE;
                    ack_d   = 1'b1;
                    err_d   = mem.err;
                    stb_d   = 1'b0;
                    mwe_d   = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    sel_d   = '0;
                end else if (mem.ack) begin
                    if (!we_q)
                        line_d[BUS_WIDTH*beat_q +: BUS_WIDTH] = mem.rdata;
                    beat_d  = beat_nxt;
                    addr_d  = base_q | (ADDR_WIDTH'(beat_nxt) << BOFF);
                    wdata_d = line_q[BUS_WIDTH*beat_nxt +: BUS_WIDTH];
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            stb_q   <= 1'b0;
            mwe_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            stb_q   <= stb_d;
            mwe_q   <= mwe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign mem.stb           = stb_q;
    assign mem.we            = mwe_q;
    assign mem.addr          = addr_q;
    assign mem.wdata         = wdata_q;
    assign mem.sel           = sel_q;
    assign mem2dcache_ack_o  = ack_q;
    assign mem2dcache_err_o  = err_q;
    assign mem2dcache_data_o = line_q;
endmodule
